// File: rtl/ib_seq_pkg.sv
// rtl/ib_seq_pkg.sv - shared FSM states, opcodes and opcode field constants for ib_sequencer
package ib_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_JUMP      = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  // The opcode occupies the top OPC_FIELD_BITS bits of an instruction word.
  localparam int OPC_FIELD_BITS = 4;

  localparam logic [OPC_FIELD_BITS-1:0] OPC_NOP  = 4'h0;
  localparam logic [OPC_FIELD_BITS-1:0] OPC_JMP  = 4'hE;
  localparam logic [OPC_FIELD_BITS-1:0] OPC_HALT = 4'hF;

endpackage

// File: rtl/ib_seq_watchdog.sv
// rtl/ib_seq_watchdog.sv - counts cycles spent waiting for exec_done and flags a timeout
module ib_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th waiting cycle so the FSM leaves on that edge.
  assign timeout = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ib_sequencer.sv
// rtl/ib_sequencer.sv - fetches instructions from an instruction buffer and issues them for execution
// Optional WAIT_DONE watchdog enabled by defining IB_SEQ_WATCHDOG_EN.
module ib_sequencer
  import ib_seq_pkg::*;
#(
  parameter int ADDR_BITS      = 10,
  parameter int INST_BITS      = 128,
  parameter int OPC_BITS       = OPC_FIELD_BITS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 wrap_mode,
  input  logic [ADDR_BITS-1:0] cfg_start_addr,
  input  logic [ADDR_BITS-1:0] cfg_end_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          inst_count,
  output logic                 ib_en,
  output logic                 ib_mode,
  output logic                 ib_incr,
  output logic                 ib_jmp,
  output logic                 ib_flag,
  output logic [ADDR_BITS-1:0] ib_start_addr,
  output logic [ADDR_BITS-1:0] ib_end_addr,
  input  logic [INST_BITS-1:0] ib_instruction,
  input  logic                 ib_init_inst_pulse,
  input  logic                 ib_complete_flag,
  output logic                 exec_valid,
  output logic [INST_BITS-1:0] exec_inst,
  input  logic                 exec_ready,
  input  logic                 exec_done
);

  state_t               state;
  state_t               state_n;
  state_t               check_next;
  logic                 wrap_q;
  logic                 exec_valid_q;
  logic                 wd_timeout;
  logic [INST_BITS-1:0] inst_reg;
  logic [OPC_BITS-1:0]  opcode;

  assign opcode = inst_reg[INST_BITS-1 -: OPC_BITS];

  always_comb begin
    check_next = (ib_complete_flag && !wrap_q) ? S_FINISH : S_FETCH;
    state_n    = state;
    case (state)
      S_IDLE:      if (start) state_n = S_FETCH;
      S_FETCH:     if (ib_init_inst_pulse) state_n = S_DECODE;
      S_DECODE: begin
        if (opcode == OPC_BITS'(OPC_NOP))       state_n = check_next;
        else if (opcode == OPC_BITS'(OPC_HALT)) state_n = S_FINISH;
        else if (opcode == OPC_BITS'(OPC_JMP))  state_n = S_JUMP;
        else                                    state_n = S_ISSUE;
      end
      S_ISSUE:     if (exec_ready) state_n = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (wd_timeout)     state_n = S_FINISH;
        else if (exec_done) state_n = check_next;
      end
      S_JUMP:      state_n = S_FETCH;
      S_FINISH:    state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_FINISH) state_n = S_FINISH;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wrap_q        <= 1'b0;
      inst_reg      <= '0;
      inst_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ib_en         <= 1'b0;
      ib_mode       <= 1'b0;
      ib_incr       <= 1'b0;
      ib_jmp        <= 1'b0;
      ib_flag       <= 1'b0;
      ib_start_addr <= '0;
      ib_end_addr   <= '0;
      exec_valid_q  <= 1'b0;
      exec_inst     <= '0;
    end else begin
      state        <= state_n;
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_FINISH);
      ib_en        <= (state_n == S_FETCH) || (state_n == S_JUMP);
      ib_incr      <= (state_n == S_FETCH);
      ib_flag      <= (state_n == S_FETCH);
      ib_jmp       <= (state_n == S_JUMP);
      ib_mode      <= (state_n == S_IDLE) ? 1'b0 : ((state == S_IDLE) ? wrap_mode : wrap_q);
      exec_valid_q <= (state_n == S_ISSUE);
      exec_inst    <= (state_n == S_ISSUE) ? inst_reg : '0;

      if (state == S_IDLE && start) begin
        wrap_q        <= wrap_mode;
        ib_start_addr <= cfg_start_addr;
        ib_end_addr   <= cfg_end_addr;
        inst_count    <= '0;
      end
      if (state == S_FETCH && state_n == S_DECODE) inst_reg <= ib_instruction;
      if (state == S_ISSUE && state_n == S_WAIT_DONE) inst_count <= inst_count + 16'd1;
      if (state_n == S_JUMP) ib_start_addr <= inst_reg[ADDR_BITS-1:0];
    end
  end

  // Abort withdraws the offer in the same cycle so no handshake can slip through.
  assign exec_valid = exec_valid_q && !abort;

`ifdef IB_SEQ_WATCHDOG_EN
  logic error_q;

  ib_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  ((state_n == S_WAIT_DONE) && (state != S_WAIT_DONE)),
    .enable (state == S_WAIT_DONE),
    .timeout(wd_timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      error_q <= 1'b0;
    end else if (state == S_WAIT_DONE && wd_timeout) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign wd_timeout = 1'b0;
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_ib_sequencer.sv
// tb/tb_ib_sequencer.sv - directed self-checking bench for ib_sequencer
module tb_ib_sequencer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, abort, wrap_mode;
  logic [9:0]   cfg_start_addr, cfg_end_addr;
  logic         busy, done, error;
  logic [15:0]  inst_count;
  logic         ib_en, ib_mode, ib_incr, ib_jmp, ib_flag;
  logic [9:0]   ib_start_addr, ib_end_addr;
  logic [127:0] ib_instruction;
  logic         ib_init_inst_pulse, ib_complete_flag;
  logic         exec_valid;
  logic [127:0] exec_inst;
  logic         exec_ready, exec_done;

  int tests = 0;
  int failed = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  ib_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .wrap_mode(wrap_mode),
    .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
    .busy(busy), .done(done), .error(error), .inst_count(inst_count),
    .ib_en(ib_en), .ib_mode(ib_mode), .ib_incr(ib_incr), .ib_jmp(ib_jmp), .ib_flag(ib_flag),
    .ib_start_addr(ib_start_addr), .ib_end_addr(ib_end_addr),
    .ib_instruction(ib_instruction), .ib_init_inst_pulse(ib_init_inst_pulse),
    .ib_complete_flag(ib_complete_flag),
    .exec_valid(exec_valid), .exec_inst(exec_inst), .exec_ready(exec_ready), .exec_done(exec_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (exec_valid === 1'b1 && exec_ready === 1'b1) hs_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish within 1 ms");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] sa, input logic [9:0] ea, input logic wm);
    cfg_start_addr = sa; cfg_end_addr = ea; wrap_mode = wm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for ib_flag, presents one instruction, returns in the DECODE cycle.
  task automatic fetch(input logic [127:0] inst, input logic cflag);
    int n = 0;
    while (ib_flag !== 1'b1 && n < 50) begin tick(); n++; end
    tests++;
    if (ib_flag !== 1'b1) begin failed++; $display("FAIL fetch_wait ib_flag=%b required 1", ib_flag); end
    ib_instruction = inst; ib_complete_flag = cflag; ib_init_inst_pulse = 1'b1;
    tick();
    ib_init_inst_pulse = 1'b0;
  endtask

  // Completes the exec handshake, returns in the first WAIT_DONE cycle.
  task automatic exec_hs();
    int n = 0;
    while (exec_valid !== 1'b1 && n < 50) begin tick(); n++; end
    tests++;
    if (exec_valid !== 1'b1) begin failed++; $display("FAIL exec_wait exec_valid=%b required 1", exec_valid); end
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
  endtask

  task automatic pulse_done();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; abort = 0; wrap_mode = 0; cfg_start_addr = '0; cfg_end_addr = '0;
    ib_instruction = '0; ib_init_inst_pulse = 0; ib_complete_flag = 0; exec_ready = 0; exec_done = 0;
    tick(); tick();
    tests++;
    if ({busy, done, error, ib_en, ib_mode, ib_incr, ib_jmp, ib_flag, exec_valid} !== 9'b0) begin
      failed++; $display("FAIL reset_flags got %b required 000000000",
                         {busy, done, error, ib_en, ib_mode, ib_incr, ib_jmp, ib_flag, exec_valid});
    end
    tests++;
    if (inst_count !== 16'd0 || ib_start_addr !== 10'd0 || ib_end_addr !== 10'd0 || exec_inst !== 128'd0) begin
      failed++; $display("FAIL reset_values count=%0d sa=%0d ea=%0d inst=%h required all 0",
                         inst_count, ib_start_addr, ib_end_addr, exec_inst);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_procedural();
    int d0 = done_cnt;
    int h0 = hs_cnt;
    logic [127:0] inst;
    do_start(10'd0, 10'd10, 1'b0);
    tests++;
    if (busy !== 1'b1 || ib_en !== 1'b1 || ib_incr !== 1'b1 || ib_flag !== 1'b1 || ib_mode !== 1'b0) begin
      failed++; $display("FAIL proc_fetch_outputs busy=%b en=%b incr=%b flag=%b mode=%b required 1 1 1 1 0",
                         busy, ib_en, ib_incr, ib_flag, ib_mode);
    end
    tests++;
    if (ib_end_addr !== 10'd10) begin failed++; $display("FAIL proc_end_addr got %0d required 10", ib_end_addr); end
    for (int i = 0; i < 11; i++) begin
      inst = {4'h1, 124'(i * 3 + 7)};
      fetch(inst, i == 10);
      tick();
      tests++;
      if (exec_valid !== 1'b1 || exec_inst !== inst) begin
        failed++; $display("FAIL proc_issue_%0d valid=%b inst=%h required 1 %h", i, exec_valid, exec_inst, inst);
      end
      exec_hs();
      pulse_done();
    end
    tests++;
    if (done !== 1'b1) begin failed++; $display("FAIL proc_done got %b required 1", done); end
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL proc_idle busy=%b done=%b required 0 0", busy, done); end
    tests++;
    if (inst_count !== 16'd11) begin failed++; $display("FAIL proc_count got %0d required 11", inst_count); end
    tests++;
    if (hs_cnt - h0 != 11 || done_cnt - d0 != 1) begin
      failed++; $display("FAIL proc_events handshakes=%0d dones=%0d required 11 1", hs_cnt - h0, done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    logic [127:0] inst;
    inst = {4'h5, 124'h0ABC_DEF0_1234};
    do_start(10'd3, 10'd7, 1'b0);
    fetch(inst, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (exec_valid !== 1'b1 || exec_inst !== inst) begin
        failed++; $display("FAIL stall_hold_%0d valid=%b inst=%h required 1 %h", k, exec_valid, exec_inst, inst);
      end
      if (k == 1) exec_done = 1'b1;
      if (k == 2) begin exec_done = 1'b0; start = 1'b1; cfg_end_addr = 10'd99; end
      if (k == 3) start = 1'b0;
      tick();
    end
    tests++;
    if (exec_valid !== 1'b1 || ib_end_addr !== 10'd7) begin
      failed++; $display("FAIL stall_ignored valid=%b end_addr=%0d required 1 7", exec_valid, ib_end_addr);
    end
    exec_hs();
    tests++;
    if (inst_count !== 16'd1 || exec_valid !== 1'b0) begin
      failed++; $display("FAIL stall_handshake count=%0d valid=%b required 1 0", inst_count, exec_valid);
    end
    tick(); tick();
    tests++;
    if (busy !== 1'b1 || ib_flag !== 1'b0 || done !== 1'b0) begin
      failed++; $display("FAIL stall_waiting busy=%b flag=%b done=%b required 1 0 0", busy, ib_flag, done);
    end
    pulse_done();
    tests++;
    if (done !== 1'b1) begin failed++; $display("FAIL stall_done got %b required 1", done); end
    tick();
  endtask

  task automatic test_jump();
    do_start(10'd5, 10'd20, 1'b0);
    tests++;
    if (ib_start_addr !== 10'd5) begin failed++; $display("FAIL jmp_start_addr got %h required 005", ib_start_addr); end
    fetch({4'hE, 114'b0, 10'h0FF}, 1'b0);
    tests++;
    if (ib_jmp !== 1'b0) begin failed++; $display("FAIL jmp_decode ib_jmp=%b required 0", ib_jmp); end
    tick();
    tests++;
    if (ib_jmp !== 1'b1 || ib_en !== 1'b1 || ib_start_addr !== 10'h0FF) begin
      failed++; $display("FAIL jmp_cycle jmp=%b en=%b addr=%h required 1 1 0ff", ib_jmp, ib_en, ib_start_addr);
    end
    tick();
    tests++;
    if (ib_jmp !== 1'b0 || ib_flag !== 1'b1 || ib_start_addr !== 10'h0FF) begin
      failed++; $display("FAIL jmp_after jmp=%b flag=%b addr=%h required 0 1 0ff", ib_jmp, ib_flag, ib_start_addr);
    end
    fetch({4'h0, 124'h55}, 1'b0);
    tick();
    tests++;
    if (ib_flag !== 1'b1 || exec_valid !== 1'b0) begin
      failed++; $display("FAIL nop_refetch flag=%b valid=%b required 1 0", ib_flag, exec_valid);
    end
    fetch({4'hF, 124'h0}, 1'b0);
    tick();
    tests++;
    if (done !== 1'b1 || inst_count !== 16'd0) begin
      failed++; $display("FAIL halt_done done=%b count=%0d required 1 0", done, inst_count);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || ib_start_addr !== 10'h0FF) begin
      failed++; $display("FAIL halt_idle busy=%b addr=%h required 0 0ff", busy, ib_start_addr);
    end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    int mode_bad = 0;
    logic [127:0] inst;
    do_start(10'd0, 10'd10, 1'b1);
    for (int i = 0; i < 51; i++) begin
      if (ib_mode !== 1'b1) mode_bad++;
      if (i == 50)          inst = {4'h2, 124'hBEEF};
      else if (i % 10 == 5) inst = {4'h3, 124'(i)};
      else                  inst = {4'h0, 124'(i)};
      fetch(inst, 1'b1);
      if (ib_mode !== 1'b1) mode_bad++;
      if (i < 50) begin
        tick();
        if (i % 10 == 5) begin exec_hs(); pulse_done(); end
      end
    end
    tests++;
    if (done_cnt != d0 || busy !== 1'b1) begin
      failed++; $display("FAIL wrap_no_finish dones=%0d busy=%b required 0 1", done_cnt - d0, busy);
    end
    tick();
    tests++;
    if (exec_valid !== 1'b1) begin failed++; $display("FAIL wrap_issue valid=%b required 1", exec_valid); end
    abort = 1'b1;
    #1;
    tests++;
    if (exec_valid !== 1'b0) begin failed++; $display("FAIL abort_drop valid=%b required 0", exec_valid); end
    tick();
    tests++;
    if (done !== 1'b1 || ib_mode !== 1'b1) begin
      failed++; $display("FAIL abort_finish done=%b mode=%b required 1 1", done, ib_mode);
    end
    abort = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || done_cnt - d0 != 1 || mode_bad != 0) begin
      failed++; $display("FAIL wrap_end busy=%b dones=%0d mode_bad=%0d required 0 1 0", busy, done_cnt - d0, mode_bad);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    do_start(10'd2, 10'd9, 1'b0);
    fetch({4'h4, 124'h1}, 1'b0);
    tick();
    exec_hs();
    tests++;
    if (busy !== 1'b1 || inst_count !== 16'd1) begin
      failed++; $display("FAIL mid_wait busy=%b count=%0d required 1 1", busy, inst_count);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, exec_valid, ib_en, ib_flag, ib_mode} !== 6'b0 || inst_count !== 16'd0 ||
        ib_start_addr !== 10'd0 || ib_end_addr !== 10'd0) begin
      failed++; $display("FAIL mid_reset flags=%b count=%0d sa=%0d ea=%0d required 0",
                         {busy, done, exec_valid, ib_en, ib_flag, ib_mode}, inst_count, ib_start_addr, ib_end_addr);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    tests++;
    if (done_cnt != d0) begin failed++; $display("FAIL mid_no_done dones=%0d required 0", done_cnt - d0); end
    do_start(10'd1, 10'd2, 1'b0);
    fetch({4'h7, 124'h2}, 1'b0); tick(); exec_hs(); pulse_done();
    fetch({4'h7, 124'h3}, 1'b1); tick(); exec_hs(); pulse_done();
    tests++;
    if (done !== 1'b1) begin failed++; $display("FAIL rerun_done got %b required 1", done); end
    tick();
    tests++;
    if (inst_count !== 16'd2 || busy !== 1'b0) begin
      failed++; $display("FAIL rerun_count count=%0d busy=%b required 2 0", inst_count, busy);
    end
  endtask

  task automatic test_watchdog();
    int d0 = done_cnt;
    int n = 0;
    do_start(10'd0, 10'd4, 1'b0);
    fetch({4'h6, 124'h9}, 1'b1);
    tick();
    exec_hs();
`ifdef IB_SEQ_WATCHDOG_EN
    while (done !== 1'b1 && n < 1100) begin tick(); n++; end
    tests++;
    if (done !== 1'b1 || error !== 1'b1) begin
      failed++; $display("FAIL wd_timeout done=%b error=%b required 1 1", done, error);
    end
    tests++;
    if (n != 1024) begin failed++; $display("FAIL wd_cycles got %0d required 1024", n); end
    tick();
    tests++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL wd_sticky error=%b busy=%b required 1 0", error, busy);
    end
    do_start(10'd0, 10'd4, 1'b0);
    tests++;
    if (error !== 1'b0) begin failed++; $display("FAIL wd_clear error=%b required 0", error); end
    abort = 1'b1; tick(); abort = 1'b0; tick();
`else
    repeat (1100) begin tick(); n++; end
    tests++;
    if (busy !== 1'b1 || done_cnt != d0 || error !== 1'b0) begin
      failed++; $display("FAIL nowd_wait busy=%b dones=%0d error=%b required 1 0 0", busy, done_cnt - d0, error);
    end
    pulse_done();
    tests++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failed++; $display("FAIL nowd_done done=%b error=%b required 1 0", done, error);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_procedural();
    test_stall();
    test_jump();
    test_wrap();
    test_reset_mid();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
